axi_arbiter: RTL and testbench
==============================

Name: axi_arbiter

Overview:
- Sits directly downstream of the core top.
- Merges the core's two AXI4-lite-style master ports onto a single AXI4-lite master port toward the memory/peripheral crossbar:
  - instruction fetch from the icache (read only);
  - data from exu/lsu (read and write).
- Allows exactly one outstanding transaction at a time and arbitrates between fetch and data round-robin.
- Forwards responses only to the granted requester.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (strobe width DATA_W/8)
- IF_ARSIZE, 3'b010, arsize driven downstream for fetch reads

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- if_arvalid  in  1  fetch read request
- if_araddr  in  ADDR_W  fetch address
- if_arready  out  1  fetch request accepted
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetch read data
- if_rresp  out  2  fetch read response
- if_rready  in  1  fetch ready for data
- d_arvalid  in  1  data read request
- d_araddr  in  ADDR_W  data read address
- d_arsize  in  3  data read size
- d_arready  out  1  data read accepted
- d_rvalid  out  1  data read valid
- d_rdata  out  DATA_W  data read data
- d_rresp  out  2  data read response
- d_rready  in  1  data ready for read data
- d_awvalid  in  1  write address valid
- d_awaddr  in  ADDR_W  write address
- d_awready  out  1  write address accepted
- d_wvalid  in  1  write data valid
- d_wdata  in  DATA_W  write data
- d_wstrb  in  DATA_W/8  write strobe
- d_wready  out  1  write data accepted
- d_bvalid  out  1  write response valid
- d_bresp  out  2  write response
- d_bready  in  1  data ready for write response
- m_arvalid / m_araddr / m_arsize / m_arready  downstream AR channel (arready in, rest out)
- m_rvalid / m_rdata / m_rresp / m_rready  downstream R channel (rready out, rest in)
- m_awvalid / m_awaddr / m_awready  downstream AW channel (awready in, rest out)
- m_wvalid / m_wdata / m_wstrb / m_wready  downstream W channel (wready in, rest out)
- m_bvalid / m_bresp / m_bready  downstream B channel (bready out, rest in)

Behaviour:
- Reset:
  - State enters IDLE; last_grant = DATA, so fetch wins the first tie.
  - All m_*valid, m_rready and m_bready are 0.
  - All upstream valid/ready outputs are 0; address/data registers are 0.
- States: IDLE, IF_AR, IF_R, D_AR, D_R, W_CAP, W_ISSUE, D_B.
- IDLE arbitration:
  - req_if = if_arvalid; req_d = d_arvalid | d_awvalid.
  - If both request, grant the one that is not last_grant; otherwise grant the sole requester.
  - Within data, d_arvalid has priority over d_awvalid.
  - The winning upstream ready is asserted combinationally in the same cycle, so the handshake completes in IDLE.
  - The grant updates last_grant.
- Fetch grant:
  - Latch if_araddr; go to IF_AR.
- Data read grant:
  - Latch d_araddr and d_arsize; go to D_AR.
- Write grant:
  - d_awready = 1, and d_wready = 1 in the same cycle.
  - Latch each channel that handshakes.
  - If both handshake, go to W_ISSUE; otherwise go to W_CAP.
- IF_AR / D_AR:
  - m_arvalid = 1 with latched addr.
  - m_arsize = IF_ARSIZE for fetch, the latched size for data.
  - On m_arready, go to IF_R / D_R.
  - No upstream ready is asserted in these states.
- IF_R / D_R:
  - m_r* pass through combinationally to the granted port only; m_rready = granted *_rready.
  - The other port's rvalid = 0.
  - On m_rvalid & m_rready, go to IDLE.
- W_CAP:
  - Hold ready high on each missing channel (awready or wready) until it is captured.
  - Once both are captured, go to W_ISSUE.
- W_ISSUE:
  - m_awvalid and m_wvalid both start at 1 from the latched values.
  - Each drops independently on its own handshake.
  - When both are done, go to D_B.
- D_B:
  - m_b* pass through to d_b*; m_bready = d_bready.
  - On handshake, go to IDLE.
- Downstream valids stay asserted until their handshake; latched payloads are stable while valid.
- Response codes (rresp/bresp, including SLVERR/DECERR) pass through unmodified; the arbiter does not retry.
- Latency:
  - Minimum 1 cycle from upstream handshake to m_arvalid/m_awvalid.
  - Response pass-through adds 0 cycles.
  - Back-to-back transactions need 1 IDLE cycle between them.
- Reset deasserted mid-transaction aborts to IDLE. Downstream recovery is the system's responsibility, since reset is global.

Test Plan:
- Single fetch:
  - Stimulus: if_araddr=0x3000_0000; m_arready on cycle 2; m_rvalid with rdata=0x0000_0413 on cycle 4.
  - Required: m_arsize=3'b010, m_araddr=0x3000_0000; if_rdata=0x0000_0413 exactly when m_rvalid&if_rready; d_rvalid stays 0.
- Simultaneous if_arvalid and d_arvalid in IDLE after reset:
  - Required: fetch granted first, data second.
  - Then both assert again: fetch granted first again, because last_grant=DATA after the data transaction.
- Data write:
  - Stimulus: awaddr=0x8000_0010, wdata=0xDEAD_BEEF, wstrb=4'b0011; d_wvalid arrives 3 cycles after d_awvalid.
  - Required: W_CAP holds wready until the W handshake; m_awvalid and m_wvalid then rise together; m_wstrb=4'b0011; bresp=2'b00 forwarded to d_bvalid.
- Downstream accepts W before AW (m_wready on cycle 1, m_awready on cycle 3):
  - Required: m_wvalid drops after cycle 1; m_awvalid holds until cycle 3; only then is D_B entered.
- Backpressure and error response:
  - Stimulus: d_rready low for 5 cycles while m_rvalid=1 with rresp=2'b10.
  - Required: m_rready=0 during those cycles, data held; SLVERR delivered on d_rresp; return to IDLE only after the handshake.
- Reset asserted (reset=0) while in W_ISSUE:
  - Required: immediately all m_*valid=0 and state=IDLE; next fetch after release completes normally.

Source files
------------

// File: rtl/axi_arbiter.sv
// rtl/axi_arbiter.sv - round-robin merge of fetch and data AXI4-lite masters onto one downstream port
module axi_arbiter #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [2:0]  IF_ARSIZE = 3'b010
) (
  input  logic                  clock,
  input  logic                  reset,
  // fetch (read only)
  input  logic                  if_arvalid,
  input  logic [ADDR_W-1:0]     if_araddr,
  output logic                  if_arready,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  output logic [1:0]            if_rresp,
  input  logic                  if_rready,
  // data read
  input  logic                  d_arvalid,
  input  logic [ADDR_W-1:0]     d_araddr,
  input  logic [2:0]            d_arsize,
  output logic                  d_arready,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic [1:0]            d_rresp,
  input  logic                  d_rready,
  // data write
  input  logic                  d_awvalid,
  input  logic [ADDR_W-1:0]     d_awaddr,
  output logic                  d_awready,
  input  logic                  d_wvalid,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_wready,
  output logic                  d_bvalid,
  output logic [1:0]            d_bresp,
  input  logic                  d_bready,
  // downstream master
  output logic                  m_arvalid,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [2:0]            m_arsize,
  input  logic                  m_arready,
  input  logic                  m_rvalid,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  output logic                  m_rready,
  output logic                  m_awvalid,
  output logic [ADDR_W-1:0]     m_awaddr,
  input  logic                  m_awready,
  output logic                  m_wvalid,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  input  logic                  m_wready,
  input  logic                  m_bvalid,
  input  logic [1:0]            m_bresp,
  output logic                  m_bready
);

  typedef enum logic [2:0] {
    IDLE, IF_AR, IF_R, D_AR, D_R, W_CAP, W_ISSUE, D_B
  } state_t;

  state_t                state;
  logic                  last_grant_d;   // 1: data was granted last, so fetch wins a tie
  logic [ADDR_W-1:0]     addr_q;         // shared by AR and AW: only one transaction in flight
  logic [2:0]            size_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wstrb_q;
  logic                  aw_got;
  logic                  w_got;
  logic                  awvalid_q;
  logic                  wvalid_q;

  logic req_d;
  logic grant_if;
  logic grant_d;
  logic wr_grant;

  assign req_d    = d_arvalid | d_awvalid;
  assign grant_if = (state == IDLE) & if_arvalid & (~req_d | last_grant_d);
  assign grant_d  = (state == IDLE) & req_d & ~grant_if;
  assign wr_grant = grant_d & ~d_arvalid;

  // Upstream handshakes complete in IDLE on the winner; W_CAP keeps asking for the missing half
  assign if_arready = grant_if;
  assign d_arready  = grant_d & d_arvalid;
  assign d_awready  = wr_grant | ((state == W_CAP) & ~aw_got);
  assign d_wready   = wr_grant | ((state == W_CAP) & ~w_got);

  // Request channels come from latched state only
  assign m_arvalid = (state == IF_AR) | (state == D_AR);
  assign m_araddr  = addr_q;
  assign m_arsize  = size_q;
  assign m_awvalid = awvalid_q;
  assign m_awaddr  = addr_q;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;

  // Responses are steered combinationally to the granted requester only
  assign if_rvalid = (state == IF_R) & m_rvalid;
  assign if_rdata  = (state == IF_R) ? m_rdata : '0;
  assign if_rresp  = (state == IF_R) ? m_rresp : 2'b00;
  assign d_rvalid  = (state == D_R) & m_rvalid;
  assign d_rdata   = (state == D_R) ? m_rdata : '0;
  assign d_rresp   = (state == D_R) ? m_rresp : 2'b00;
  assign m_rready  = ((state == IF_R) & if_rready) | ((state == D_R) & d_rready);
  assign d_bvalid  = (state == D_B) & m_bvalid;
  assign d_bresp   = (state == D_B) ? m_bresp : 2'b00;
  assign m_bready  = (state == D_B) & d_bready;

  // Transaction sequencer: arbitration, payload capture and downstream valid tracking
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      addr_q       <= '0;
      size_q       <= 3'b000;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_got       <= 1'b0;
      w_got        <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_if) begin
            last_grant_d <= 1'b0;
            addr_q       <= if_araddr;
            size_q       <= IF_ARSIZE;
            state        <= IF_AR;
          end else if (grant_d) begin
            last_grant_d <= 1'b1;
            if (d_arvalid) begin
              addr_q <= d_araddr;
              size_q <= d_arsize;
              state  <= D_AR;
            end else begin
              addr_q <= d_awaddr;
              if (d_wvalid) begin
                wdata_q   <= d_wdata;
                wstrb_q   <= d_wstrb;
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state     <= W_ISSUE;
              end else begin
                aw_got <= 1'b1;
                state  <= W_CAP;
              end
            end
          end
        end
        IF_AR: if (m_arready) state <= IF_R;
        D_AR:  if (m_arready) state <= D_R;
        IF_R:  if (m_rvalid && if_rready) state <= IDLE;
        D_R:   if (m_rvalid && d_rready) state <= IDLE;
        W_CAP: begin
          if (!aw_got && d_awvalid) begin
            addr_q <= d_awaddr;
            aw_got <= 1'b1;
          end
          if (!w_got && d_wvalid) begin
            wdata_q <= d_wdata;
            wstrb_q <= d_wstrb;
            w_got   <= 1'b1;
          end
          if ((aw_got || d_awvalid) && (w_got || d_wvalid)) begin
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state     <= W_ISSUE;
          end
        end
        W_ISSUE: begin
          if (awvalid_q && m_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_wready)   wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) state <= D_B;
        end
        D_B:   if (m_bvalid && d_bready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// tb/tb_axi_arbiter.sv - randomized transaction-level check of axi_arbiter against a round-robin model
module tb_axi_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_arvalid, if_arready, if_rvalid, if_rready;
  logic [31:0] if_araddr, if_rdata;
  logic [1:0]  if_rresp;
  logic        d_arvalid, d_arready, d_rvalid, d_rready;
  logic [31:0] d_araddr, d_rdata;
  logic [2:0]  d_arsize;
  logic [1:0]  d_rresp;
  logic        d_awvalid, d_awready, d_wvalid, d_wready, d_bvalid, d_bready;
  logic [31:0] d_awaddr, d_wdata;
  logic [3:0]  d_wstrb;
  logic [1:0]  d_bresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic [2:0]  m_arsize;
  logic [1:0]  m_rresp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp;

  axi_arbiter #(.ADDR_W(32), .DATA_W(32), .IF_ARSIZE(3'b010)) dut (
    .clock(clock), .reset(reset),
    .if_arvalid(if_arvalid), .if_araddr(if_araddr), .if_arready(if_arready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_rresp(if_rresp), .if_rready(if_rready),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arsize(d_arsize), .d_arready(d_arready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rresp(d_rresp), .d_rready(d_rready),
    .d_awvalid(d_awvalid), .d_awaddr(d_awaddr), .d_awready(d_awready),
    .d_wvalid(d_wvalid), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wready(d_wready),
    .d_bvalid(d_bvalid), .d_bresp(d_bresp), .d_bready(d_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arsize(m_arsize), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending requests per source and who won last
  bit          p_if, p_dr, p_dw;
  bit          last_d;
  logic [31:0] if_addr, dr_addr, dw_addr, dw_data;
  logic [2:0]  dr_size;
  logic [3:0]  dw_strb;
  int          dw_delay;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic quiet();
    if_rready = 1'b0; d_rready = 1'b0; d_bready = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
  endtask

  task automatic apply_req();
    if_arvalid = p_if; if_araddr = if_addr;
    d_arvalid  = p_dr; d_araddr  = dr_addr; d_arsize = dr_size;
    d_awvalid  = p_dw; d_awaddr  = dw_addr;
    d_wvalid   = p_dw && (dw_delay == 0);
    d_wdata    = dw_data; d_wstrb = dw_strb;
  endtask

  task automatic new_if();
    p_if = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
  endtask
  task automatic new_dr();
    p_dr = 1'b1; dr_addr = $urandom; dr_size = 3'($urandom_range(0, 2));
  endtask
  task automatic new_dw();
    p_dw = 1'b1; dw_addr = $urandom; dw_data = $urandom;
    dw_strb = 4'($urandom); dw_delay = int'($urandom_range(0, 3));
  endtask

  task automatic do_read(input bit is_if);
    logic [31:0] ea;
    logic [2:0]  es;
    logic [31:0] rd;
    logic [1:0]  rr;
    logic        rdy;
    int ad, rv, rb;
    ea = is_if ? if_addr : dr_addr;
    es = is_if ? 3'b010 : dr_size;
    ad = int'($urandom_range(0, 3));
    for (int k = 0; k <= ad; k++) begin
      @(negedge clock); quiet(); apply_req();
      m_arready = (k == ad);
      #1;
      check("m_arvalid", 64'(m_arvalid), 64'(1));
      check("m_araddr", 64'(m_araddr), 64'(ea));
      check("m_arsize", 64'(m_arsize), 64'(es));
      check("up_ready_busy", 64'({if_arready, d_arready, d_awready}), 64'(0));
    end
    rv = int'($urandom_range(0, 3));
    rb = int'($urandom_range(0, 5));
    rd = $urandom;
    rr = 2'($urandom);
    for (int k = 0; k <= rv + rb; k++) begin
      @(negedge clock); quiet(); apply_req();
      m_rvalid = (k >= rv); m_rdata = rd; m_rresp = rr;
      rdy = (k >= rv + rb);
      if (is_if) begin if_rready = rdy; d_rready = 1'b1; end
      else       begin d_rready = rdy; if_rready = 1'b1; end
      #1;
      check("rvalid_granted", 64'(is_if ? if_rvalid : d_rvalid), 64'(k >= rv));
      check("rvalid_other", 64'(is_if ? d_rvalid : if_rvalid), 64'(0));
      check("m_rready", 64'(m_rready), 64'(rdy));
      if (k == rv + rb) begin
        check("rdata", 64'(is_if ? if_rdata : d_rdata), 64'(rd));
        check("rresp", 64'(is_if ? if_rresp : d_rresp), 64'(rr));
      end
    end
  endtask

  task automatic do_write();
    logic [1:0] br;
    logic       rdy;
    int a, w, bv, bb, last;
    for (int i = 1; i <= dw_delay; i++) begin
      @(negedge clock); quiet(); apply_req();
      d_wvalid = (i == dw_delay); d_wdata = dw_data; d_wstrb = dw_strb;
      #1;
      check("wcap_wready", 64'(d_wready), 64'(1));
      check("wcap_awready", 64'(d_awready), 64'(0));
      check("wcap_m_valid", 64'({m_awvalid, m_wvalid}), 64'(0));
    end
    a = int'($urandom_range(0, 3));
    w = int'($urandom_range(0, 3));
    last = (a > w) ? a : w;
    for (int k = 0; k <= last; k++) begin
      @(negedge clock); quiet(); apply_req();
      m_awready = (k == a); m_wready = (k == w);
      #1;
      check("m_awvalid", 64'(m_awvalid), 64'(k <= a));
      check("m_wvalid", 64'(m_wvalid), 64'(k <= w));
      if (k <= a) check("m_awaddr", 64'(m_awaddr), 64'(dw_addr));
      if (k <= w) check("m_wdata", 64'({m_wstrb, m_wdata}), 64'({dw_strb, dw_data}));
    end
    bv = int'($urandom_range(0, 3));
    bb = int'($urandom_range(0, 4));
    br = 2'($urandom);
    for (int k = 0; k <= bv + bb; k++) begin
      @(negedge clock); quiet(); apply_req();
      m_bvalid = (k >= bv); m_bresp = br;
      rdy = (k >= bv + bb);
      d_bready = rdy;
      #1;
      check("d_bvalid", 64'(d_bvalid), 64'(k >= bv));
      check("m_bready", 64'(m_bready), 64'(rdy));
      check("rvalid_in_b", 64'({if_rvalid, d_rvalid}), 64'(0));
      if (k == bv + bb) check("d_bresp", 64'(d_bresp), 64'(br));
    end
  endtask

  // mode 0: random new requests, 1: all three, 2: fetch only, 3: no new requests
  task automatic round(input int mode);
    bit g_if, g_d;
    @(negedge clock); quiet();
    if (mode == 1) begin new_if(); new_dr(); new_dw(); end
    else if (mode == 2) begin if (!p_if) new_if(); end
    else if (mode == 0) begin
      if (!p_if && $urandom_range(0, 1) == 1) new_if();
      if (!p_dr && $urandom_range(0, 2) == 0) new_dr();
      if (!p_dw && $urandom_range(0, 2) == 0) new_dw();
      if (!(p_if || p_dr || p_dw)) new_if();
    end
    apply_req();
    #1;
    g_if = p_if && (!(p_dr || p_dw) || last_d);
    g_d  = (p_dr || p_dw) && !g_if;
    check("grant", 64'({if_arready, d_arready, d_awready, d_wready}),
          64'({g_if, g_d && p_dr, g_d && !p_dr, g_d && !p_dr}));
    check("idle_m_arvalid", 64'(m_arvalid), 64'(0));
    if (g_if) begin
      last_d = 1'b0; p_if = 1'b0; do_read(1'b1);
    end else if (g_d) begin
      last_d = 1'b1;
      if (p_dr) begin p_dr = 1'b0; do_read(1'b0); end
      else begin p_dw = 1'b0; do_write(); end
    end
  endtask

  initial begin
    p_if = 0; p_dr = 0; p_dw = 0; last_d = 1'b1;
    if_addr = '0; dr_addr = '0; dr_size = '0; dw_addr = '0; dw_data = '0; dw_strb = '0; dw_delay = 0;
    quiet(); apply_req();
    repeat (3) @(negedge clock);
    #1;
    check("rst_m_valids", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 64'(0));
    check("rst_up", 64'({if_arready, d_arready, d_awready, d_wready, if_rvalid, d_rvalid, d_bvalid}), 64'(0));
    check("rst_regs", 64'({m_araddr, m_wdata}), 64'(0));
    @(negedge clock); reset = 1'b1;

    // simultaneous fetch and data after reset: fetch first, then data
    round(1);
    for (int i = 0; i < 150; i++) round(0);
    for (int i = 0; i < 4; i++) round(3);

    // reset while in W_ISSUE
    p_if = 0; p_dr = 0; p_dw = 0;
    dw_addr = 32'h8000_0010; dw_data = 32'hDEAD_BEEF; dw_strb = 4'b0011; dw_delay = 0; p_dw = 1'b1;
    @(negedge clock); quiet(); apply_req(); #1;
    check("rst_wr_grant", 64'({if_arready, d_arready, d_awready, d_wready}), 64'(4'b0011));
    p_dw = 1'b0;
    @(negedge clock); quiet(); apply_req(); #1;
    check("w_issue_valids", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
    reset = 1'b0;
    #1;
    check("rst_abort_valids", 64'({m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}), 64'(0));
    @(negedge clock); reset = 1'b1; last_d = 1'b1;
    if_addr = 32'h3000_0000; p_if = 1'b1;
    round(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
